// File: rtl/aes_block_stream_adapter.sv
// aes_block_stream_adapter: packs 32-bit plaintext words into 128-bit blocks,
// launches the iterative AES core, and unpacks the results onto the sink stream.
// Optional feature macro: AES_CORE_TIMEOUT_EN (core response watchdog).
module aes_block_stream_adapter #(
    parameter int NB_BLOCKS_W    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic                   enable_i,
    input  logic [NB_BLOCKS_W-1:0] nb_blocks_i,
    input  logic [31:0]            pt_data_i,
    input  logic                   pt_valid_i,
    output logic                   pt_ready_o,
    output logic [31:0]            ct_data_o,
    output logic                   ct_valid_o,
    input  logic                   ct_ready_i,
    output logic                   core_start_o,
    output logic [127:0]           core_block_o,
    input  logic                   core_done_i,
    input  logic [127:0]           core_block_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NB_BLOCKS_W-1:0] blocks_done_o,
    output logic                   timeout_err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GATHER = 3'd1;
    localparam logic [2:0] S_CORE   = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]             state;
    logic [1:0]             word_idx;
    logic [NB_BLOCKS_W-1:0] nb_lat;
    logic [NB_BLOCKS_W-1:0] blocks_done;
    logic [127:0]           in_buf;
    logic [127:0]           out_buf;
    logic                   core_start;
    logic                   ct_valid;
    logic                   done;
    logic                   pt_hs;
    logic                   ct_hs;
    logic                   timeout_hit;
    logic [6:0]             word_ofs;

    // Word 0 sits in the top 32 bits, so the bit offset is (3 - idx) * 32.
    assign word_ofs = {~word_idx, 5'd0};

    // A clear in the same cycle must not consume a plaintext word.
    assign pt_ready_o = (state == S_GATHER) && enable_i && !clear_i;
    assign pt_hs      = pt_valid_i && pt_ready_o;
    assign ct_hs      = ct_valid && ct_ready_i;

    // Present the current output word straight from the result register.
    always_comb begin
        ct_data_o = out_buf[word_ofs +: 32];
    end

`ifdef AES_CORE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_err;

    // Counts cycles spent in CORE; value k means k cycles after the launch pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              tmo_cnt <= '0;
        else if (clear_i)          tmo_cnt <= '0;
        else if (state == S_CORE)  tmo_cnt <= tmo_cnt + 1'b1;
        else                       tmo_cnt <= '0;
    end

    // Fires so that done/error become visible exactly TIMEOUT_CYCLES after launch.
    assign timeout_hit = (state == S_CORE) && !core_start && !core_done_i &&
                         (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, only reset or clear drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         tmo_err <= 1'b0;
        else if (clear_i)     tmo_err <= 1'b0;
        else if (timeout_hit) tmo_err <= 1'b1;
    end

    assign timeout_err_o = tmo_err;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Main control FSM plus data registers; clear outranks every other event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            nb_lat      <= '0;
            blocks_done <= '0;
            in_buf      <= '0;
            out_buf     <= '0;
            core_start  <= 1'b0;
            ct_valid    <= 1'b0;
            done        <= 1'b0;
        end else if (clear_i) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            nb_lat      <= '0;
            blocks_done <= '0;
            core_start  <= 1'b0;
            ct_valid    <= 1'b0;
            done        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        nb_lat      <= nb_blocks_i;
                        blocks_done <= '0;
                        word_idx    <= '0;
                        state       <= (nb_blocks_i == '0) ? S_DONE : S_GATHER;
                    end
                end
                S_GATHER: begin
                    if (pt_hs) begin
                        in_buf[word_ofs +: 32] <= pt_data_i;
                        word_idx               <= word_idx + 2'd1;
                        if (word_idx == 2'd3) begin
                            state      <= S_CORE;
                            core_start <= 1'b1;
                        end
                    end
                end
                S_CORE: begin
                    // A done coinciding with our own launch pulse is stale.
                    if (timeout_hit) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (!core_start && core_done_i) begin
                        out_buf  <= core_block_i;
                        word_idx <= '0;
                        ct_valid <= enable_i;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (ct_hs) begin
                        word_idx <= word_idx + 2'd1;
                        if (word_idx == 2'd3) begin
                            ct_valid    <= 1'b0;
                            blocks_done <= blocks_done + NB_BLOCKS_W'(1);
                            state <= (blocks_done + NB_BLOCKS_W'(1) == nb_lat) ? S_DONE : S_GATHER;
                        end else begin
                            ct_valid <= enable_i;
                        end
                    end else if (!ct_valid && enable_i) begin
                        ct_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ct_valid_o    = ct_valid;
    assign core_start_o  = core_start;
    assign core_block_o  = in_buf;
    assign busy_o        = (state != S_IDLE);
    assign done_o        = done;
    assign blocks_done_o = blocks_done;

endmodule

// File: tb/tb_aes_block_stream_adapter.sv
// Self-checking bench for aes_block_stream_adapter: randomized streams against a
// word-level scoreboard, with a behavioural AES core stand-in (block ^ mask).
module tb_aes_block_stream_adapter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear_i = 1'b0;
    logic         start_i = 1'b0;
    logic         enable_i = 1'b0;
    logic [15:0]  nb_blocks_i = '0;
    logic [31:0]  pt_data_i = '0;
    logic         pt_valid_i = 1'b0;
    logic         pt_ready_o;
    logic [31:0]  ct_data_o;
    logic         ct_valid_o;
    logic         ct_ready_i = 1'b0;
    logic         core_start_o;
    logic [127:0] core_block_o;
    logic         core_done_i = 1'b0;
    logic [127:0] core_block_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [15:0]  blocks_done_o;
    logic         timeout_err_o;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] mask = '1;
    logic [127:0] rsp_blk;
    int           core_lat = 10;
    bit           core_en = 1'b1;

    aes_block_stream_adapter #(.NB_BLOCKS_W(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .start_i(start_i),
        .enable_i(enable_i), .nb_blocks_i(nb_blocks_i), .pt_data_i(pt_data_i),
        .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .ct_data_o(ct_data_o),
        .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .core_start_o(core_start_o),
        .core_block_o(core_block_o), .core_done_i(core_done_i), .core_block_i(core_block_i),
        .busy_o(busy_o), .done_o(done_o), .blocks_done_o(blocks_done_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    // Core stand-in: answers core_lat cycles after each launch with block ^ mask.
    initial forever begin
        @(negedge clk);
        if (core_en && core_start_o) begin
            rsp_blk = core_block_o;
            repeat (core_lat) @(posedge clk);
            #1 core_done_i = 1'b1; core_block_i = rsp_blk ^ mask;
            @(posedge clk);
            #1 core_done_i = 1'b0;
        end
    end

    // Drive one job; stops early after stop_starts launches or first ct_valid if asked.
    task automatic run_job(input int nb, input int vpct, input int rpct, input bit tog,
                           input bit fixed, input int stop_starts, input bit stop_ct);
        logic [31:0] pt_q[$];
        logic [31:0] exp_q[$];
        logic [31:0] fw[4];
        logic [31:0] w, e, prev_data;
        logic [127:0] eblk;
        int n, pi, starts, cts, first_pt, last_ct;
        bit seen_done, prev_stall, stopped;
        fw[0] = 32'h00112233; fw[1] = 32'h44556677; fw[2] = 32'h8899AABB; fw[3] = 32'hCCDDEEFF;
        n = nb * 4; pi = 0; starts = 0; cts = 0; first_pt = -1; last_ct = -1;
        seen_done = 0; prev_stall = 0; stopped = 0; prev_data = '0;
        for (int i = 0; i < n; i++) begin
            w = fixed ? fw[i % 4] : $urandom;
            pt_q.push_back(w);
            exp_q.push_back(w ^ 32'(mask >> (32 * (3 - (i % 4)))));
        end
        @(posedge clk); #1;
        enable_i = 1'b1; start_i = 1'b1; nb_blocks_i = 16'(nb);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (core_start_o) begin
                if (4 * starts + 3 < n) begin
                    eblk = {pt_q[4*starts], pt_q[4*starts+1], pt_q[4*starts+2], pt_q[4*starts+3]};
                    checks++;
                    if (core_block_o !== eblk) begin
                        failures++;
                        $display("FAIL core_block got=%h exp=%h", core_block_o, eblk);
                    end
                end
                starts++;
            end
            if (prev_stall) begin
                checks++;
                if (!ct_valid_o || ct_data_o !== prev_data) begin
                    failures++;
                    $display("FAIL ct_hold valid=%b data=%h exp=%h", ct_valid_o, ct_data_o, prev_data);
                end
            end
            prev_stall = ct_valid_o && !ct_ready_i;
            prev_data  = ct_data_o;
            if (pt_valid_i && pt_ready_o) begin
                if (first_pt < 0) first_pt = cyc;
                pi++;
            end
            if (ct_valid_o && ct_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ct_extra got=%h exp=none", ct_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (ct_data_o !== e) begin
                        failures++;
                        $display("FAIL ct_word %0d got=%h exp=%h", cts, ct_data_o, e);
                    end
                end
                cts++;
                last_ct = cyc;
            end
            if (done_o) begin seen_done = 1; break; end
            if (stop_starts != 0 && starts == stop_starts) begin stopped = 1; break; end
            if (stop_ct && ct_valid_o) begin stopped = 1; break; end
            @(posedge clk); #1;
            start_i    = 1'b0;
            pt_valid_i = (pi < n) && ($urandom_range(99) < vpct);
            pt_data_i  = (pi < n) ? pt_q[pi] : 32'h0;
            ct_ready_i = ($urandom_range(99) < rpct);
            enable_i   = tog ? ($urandom_range(3) != 0) : 1'b1;
        end
        if (!stopped) begin
            checks++;
            if (!seen_done) begin
                failures++;
                $display("FAIL job_done got=timeout exp=done_o");
            end
            checks++;
            if (exp_q.size() != 0 || cts != n) begin
                failures++;
                $display("FAIL ct_count got=%0d exp=%0d", cts, n);
            end
            checks++;
            if (blocks_done_o !== 16'(nb) || starts != nb) begin
                failures++;
                $display("FAIL blocks_done got=%0d/%0d exp=%0d", blocks_done_o, starts, nb);
            end
            if (fixed) begin
                checks++;
                if (last_ct - first_pt + 1 != 4 + 1 + core_lat + 4) begin
                    failures++;
                    $display("FAIL block_latency got=%0d exp=%0d", last_ct - first_pt + 1, 4 + 1 + core_lat + 4);
                end
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0; pt_valid_i = 1'b0; ct_ready_i = 1'b0; enable_i = 1'b1;
        if (!stopped) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse done=%b busy=%b exp=0/0", done_o, busy_o);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({pt_ready_o, ct_valid_o, core_start_o, busy_o, done_o, timeout_err_o} !== 6'b0 ||
            ct_data_o !== '0 || core_block_o !== '0 || blocks_done_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b %h %h %h exp=0",
                     {pt_ready_o, ct_valid_o, core_start_o, busy_o, done_o, timeout_err_o},
                     ct_data_o, core_block_o, blocks_done_o);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || pt_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b ready=%b exp=0/0", busy_o, pt_ready_o);
        end
    endtask

    task automatic test_single_block;
        mask = '1;
        run_job(1, 100, 100, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_zero_blocks;
        bit bad;
        int done_at;
        bad = 0; done_at = -1;
        @(posedge clk); #1 start_i = 1'b1; nb_blocks_i = 16'd0; enable_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (pt_ready_o || core_start_o) bad = 1;
            if (done_o && done_at < 0) done_at = c;
            else if (done_o) bad = 1;
            @(posedge clk); #1 start_i = 1'b0;
        end
        checks++;
        if (done_at != 2 || bad) begin
            failures++;
            $display("FAIL zero_blocks done_at=%0d bad=%0d exp=2/0", done_at, bad);
        end
    endtask

    task automatic test_backpressure;
        mask = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 3 + $urandom_range(8);
        run_job(3, 60, 50, 1'b1, 1'b0, 0, 1'b0);
        core_lat = 10;
    endtask

    task automatic test_back_to_back;
        mask = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 1;
        run_job(5, 100, 100, 1'b0, 1'b0, 0, 1'b0);
        core_lat = 10;
    endtask

    task automatic test_clear_mid_op;
        bit bad;
        bad = 0;
        mask = {$urandom, $urandom, $urandom, $urandom};
        run_job(4, 100, 100, 1'b0, 1'b0, 2, 1'b0);
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || blocks_done_o !== '0 || ct_valid_o !== 1'b0 || core_start_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_state busy=%b blocks=%0d ctv=%b cs=%b exp=0", busy_o, blocks_done_o, ct_valid_o, core_start_o);
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (busy_o || ct_valid_o || done_o) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL late_core_done got=activity exp=idle");
        end
        run_job(1, 100, 100, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_timeout;
        int k;
        core_en = 1'b0;
        run_job(1, 100, 100, 1'b0, 1'b0, 1, 1'b0);
`ifdef AES_CORE_TIMEOUT_EN
        k = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done_o) begin k = c; break; end
        end
        checks++;
        if (k != 64 || timeout_err_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout done_at=%0d err=%b exp=64/1", k, timeout_err_o);
        end
`else
        k = 0;
        repeat (100) @(negedge clk);
        checks++;
        if (timeout_err_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout err=%b busy=%b exp=0/1", timeout_err_o, busy_o);
        end
`endif
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout_err_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear err=%b busy=%b exp=0/0", timeout_err_o, busy_o);
        end
        core_en = 1'b1;
    endtask

    task automatic test_reset_mid_emit;
        mask = {$urandom, $urandom, $urandom, $urandom};
        run_job(2, 100, 0, 1'b0, 1'b0, 0, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({pt_ready_o, ct_valid_o, core_start_o, busy_o, done_o, timeout_err_o} !== 6'b0 ||
            ct_data_o !== '0 || core_block_o !== '0 || blocks_done_o !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b %h %h exp=0",
                     {pt_ready_o, ct_valid_o, core_start_o, busy_o, done_o, timeout_err_o},
                     ct_data_o, blocks_done_o);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (15) @(posedge clk);
        run_job(1, 100, 100, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_zero_blocks();
        test_backpressure();
        test_back_to_back();
        test_clear_mid_op();
        test_timeout();
        test_reset_mid_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
